// File: rtl/move_key_ctrl.sv
// Push-button conditioner: sync, debounce, then one-shot plus auto-repeat
// left/right step strobes for the ball x-position updater.
module move_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_left_raw,
    input  logic key_right_raw,
    output logic left,
    output logic right,
    output logic left_level,
    output logic right_level
);

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] RD_LOAD = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RP_LOAD = 26'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // bit 0 = left key, bit 1 = right key
    logic [1:0]        raw;
    logic [1:0]        sync1_q;
    logic [1:0]        sync2_q;
    logic [1:0]        lvl_q;
    logic [1:0]        lvl_d;
    logic [1:0][23:0]  cnt_q;
    logic [1:0][23:0]  cnt_d;

    state_t            state_q;
    logic [25:0]       tmr_q;
    logic              dir_q;
    logic              left_q;
    logic              right_q;
    logic              only_dir;

    assign raw = {key_right_raw, key_left_raw};

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != lvl_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    lvl_d[k] = ~lvl_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    // dir_q = 0 serves left, 1 serves right
    assign only_dir = dir_q ? (lvl_q[1] & ~lvl_q[0])
                            : (lvl_q[0] & ~lvl_q[1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            dir_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lvl_q[0] ^ lvl_q[1]) begin
                        left_q  <= lvl_q[0];
                        right_q <= lvl_q[1];
                        dir_q   <= lvl_q[1];
                        tmr_q   <= RD_LOAD;
                        state_q <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!only_dir) begin
                        tmr_q   <= '0;
                        state_q <= IDLE;
                    end else if (tmr_q == 26'd0) begin
                        left_q  <= ~dir_q;
                        right_q <= dir_q;
                        tmr_q   <= RP_LOAD;
                        state_q <= REPEAT;
                    end else begin
                        tmr_q   <= tmr_q - 26'd1;
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign left        = left_q;
    assign right       = right_q;
    assign left_level  = lvl_q[0];
    assign right_level = lvl_q[1];

endmodule

// File: tb/tb_move_key_ctrl.sv
// Self-checking bench for move_key_ctrl against a schedule-based
// reference model (sliding-window debounce, strobe times by arithmetic).
module tb_move_key_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic kl = 1'b0;
    logic kr = 1'b0;
    logic left, right, left_level, right_level;

    int n_cmp = 0;
    int n_bad = 0;

    move_key_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_left_raw(kl),
        .key_right_raw(kr),
        .left(left),
        .right(right),
        .left_level(left_level),
        .right_level(right_level)
    );

    always #5 clk = ~clk;

    // Reference model
    logic           m_s1l = 0, m_s2l = 0, m_s1r = 0, m_s2r = 0;
    logic [DEB-1:0] m_win_l = '0, m_win_r = '0;
    logic           m_ll = 0, m_rl = 0, m_left = 0, m_right = 0;
    logic           m_active = 0, m_dir = 0;
    int             m_n = 0, m_start = 0, m_d;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1l = 0; m_s2l = 0; m_s1r = 0; m_s2r = 0;
            m_win_l = '0; m_win_r = '0;
            m_ll = 0; m_rl = 0; m_left = 0; m_right = 0;
            m_active = 0; m_dir = 0; m_n = 0; m_start = 0;
        end else begin
            m_n++;
            m_left = 0;
            m_right = 0;
            if (m_active) begin
                if (m_dir ? (m_rl && !m_ll) : (m_ll && !m_rl)) begin
                    m_d = m_n - m_start;
                    if (m_d == RD || (m_d > RD && (m_d - RD) % RP == 0)) begin
                        m_left = !m_dir;
                        m_right = m_dir;
                    end
                end else begin
                    m_active = 0;
                end
            end else if (m_ll != m_rl) begin
                m_active = 1;
                m_dir = m_rl;
                m_start = m_n;
                m_left = m_ll;
                m_right = m_rl;
            end
            m_win_l = {m_win_l[DEB-2:0], m_s2l};
            m_win_r = {m_win_r[DEB-2:0], m_s2r};
            if (m_win_l == {DEB{~m_ll}}) m_ll = ~m_ll;
            if (m_win_r == {DEB{~m_rl}}) m_rl = ~m_rl;
            m_s2l = m_s1l; m_s1l = kl;
            m_s2r = m_s1r; m_s1r = kr;
        end
    end

    task automatic test_reset();
        int first;
        reset = 0; kl = 1; kr = 1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outs got=%b want=0000",
                         {left, right, left_level, right_level});
            end
        end
        reset = 1; kr = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL reset_model c=%0d got=%b want=%b", i,
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
            if (left && first < 0) first = i;
        end
        n_cmp++;
        if (first != 6) begin
            n_bad++;
            $display("FAIL reset_first_strobe got=%0d want=6", first);
        end
        kl = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL reset_settle got=%b want=%b",
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
        end
    endtask

    task automatic test_clean_press();
        int lr;
        int st[$];
        int want[6] = '{6, 16, 19, 22, 25, 28};
        lr = -1;
        kl = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl} || right !== 1'b0) begin
                n_bad++;
                $display("FAIL press_model c=%0d got=%b want=%b", i,
                         {left, right, left_level, right_level},
                         {m_left, 1'b0, m_ll, m_rl});
            end
            if (left_level && lr < 0) lr = i;
            if (left) st.push_back(i);
        end
        n_cmp++;
        if (lr != 5) begin
            n_bad++;
            $display("FAIL press_level_rise got=%0d want=5", lr);
        end
        n_cmp++;
        if (st.size() != 6) begin
            n_bad++;
            $display("FAIL press_strobe_count got=%0d want=6", st.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (st[k] != want[k]) begin
                    n_bad++;
                    $display("FAIL press_strobe_time k=%0d got=%0d want=%0d",
                             k, st[k], want[k]);
                end
            end
        end
        kl = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL press_release got=%b want=%b",
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
        end
    endtask

    task automatic test_bounce();
        int hi, lo, cyc;
        logic seen;
        seen = 0;
        cyc = 0;
        while (cyc < 40) begin
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            for (int j = 0; j < hi + lo; j++) begin
                @(negedge clk);
                n_cmp++;
                if ({left, right, left_level, right_level} !==
                    {m_left, m_right, m_ll, m_rl}) begin
                    n_bad++;
                    $display("FAIL bounce_model got=%b want=%b",
                             {left, right, left_level, right_level},
                             {m_left, m_right, m_ll, m_rl});
                end
                if (right || right_level) seen = 1;
                kr = (j < hi);
                cyc++;
            end
        end
        kr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (right || right_level) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_right got=%b want=0", seen);
        end
    endtask

    task automatic test_simultaneous();
        int rl_at, fall, stray;
        int rt[$];
        kl = 1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL simul_hold got=%b want=%b",
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
        end
        kr = 1;
        rl_at = -1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL simul_both got=%b want=%b",
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
            if (rl_at >= 0 && (left || right)) stray++;
            if (right_level && rl_at < 0) rl_at = i;
        end
        n_cmp++;
        if (rl_at != 5 || stray != 0) begin
            n_bad++;
            $display("FAIL simul_stop rise=%0d stray=%0d want rise=5 stray=0",
                     rl_at, stray);
        end
        kl = 0;
        fall = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL simul_swap got=%b want=%b",
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
            if (!left_level && fall < 0) fall = i;
            if (right) rt.push_back(i);
        end
        n_cmp++;
        if (fall < 0 || rt.size() < 2) begin
            n_bad++;
            $display("FAIL simul_right_pulses fall=%0d n=%0d want n>=2",
                     fall, rt.size());
        end else begin
            n_cmp++;
            if (rt[0] - fall < 1 || rt[0] - fall > 2) begin
                n_bad++;
                $display("FAIL simul_first_right got=%0d want=1..2",
                         rt[0] - fall);
            end
            n_cmp++;
            if (rt[1] - rt[0] != RD) begin
                n_bad++;
                $display("FAIL simul_second_right got=%0d want=%0d",
                         rt[1] - rt[0], RD);
            end
        end
        kr = 0;
        for (int i = 0; i < 15; i++) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int first, stray;
        kl = 1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i == 19) begin
                n_cmp++;
                if (left !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rmid_pre_strobe got=%b want=1", left);
                end
            end
        end
        reset = 0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({left, right, left_level, right_level} !== 4'b0000) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL rmid_in_reset got=%0d want=0", stray);
        end
        reset = 1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL rmid_model c=%0d got=%b want=%b", i,
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
            if (left && first < 0) first = i;
        end
        n_cmp++;
        if (first != 6) begin
            n_bad++;
            $display("FAIL rmid_first_strobe got=%0d want=6", first);
        end
        kl = 0;
        for (int i = 0; i < 15; i++) @(negedge clk);
    endtask

    task automatic test_short_tap();
        int nl, nr;
        nl = 0;
        nr = 0;
        kl = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({left, right, left_level, right_level} !==
                {m_left, m_right, m_ll, m_rl}) begin
                n_bad++;
                $display("FAIL tap_model c=%0d got=%b want=%b", i,
                         {left, right, left_level, right_level},
                         {m_left, m_right, m_ll, m_rl});
            end
            if (left) nl++;
            if (right) nr++;
            if (i == 5) kl = 0;
        end
        n_cmp++;
        if (nl != 1 || nr != 0) begin
            n_bad++;
            $display("FAIL tap_count left=%0d right=%0d want 1/0", nl, nr);
        end
    endtask

    always @(negedge clk) begin
        if (left && right) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_strobes got=11 want=not both");
        end
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_short_tap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
